// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the uart_rx peripheral: FSM states, register map,
// STATUS bit positions and the baud-tick divisor helper.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  localparam logic [3:0] SAMPLE_POINT = 4'd7;

  localparam logic REG_RXDATA = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int unsigned ST_AVAIL_BIT = 0;
  localparam int unsigned ST_FULL_BIT  = 1;
  localparam int unsigned ST_OVR_BIT   = 2;
  localparam int unsigned ST_FERR_BIT  = 3;
  localparam int unsigned ST_CNT_LSB   = 8;
  localparam int unsigned ST_CNT_W     = 7;

  // 16x oversample divisor, truncated, never below one clock
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    int unsigned d;
    d = clk_hz / (baud * 16);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointer wrap, occupancy count and full/empty flags.
// A push while full succeeds only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver on the picorv32 native bus: synchroniser, 16x tick, frame FSM,
// receive FIFO, sticky overrun/frame-error flags and a one-cycle-latency register port.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 80000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  input  logic        serialIn,
  output logic        rx_irq
);

  localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             sync1_q, rx_s_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;

  rx_state_e        state_q, state_d;
  logic [3:0]       samp_q, samp_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             sample;
  logic             push, ferr_set;

  logic             ovr_q, ovr_d, ferr_q, ferr_d;
  logic             ready_q, ready_d, irq_q;
  logic [31:0]      rdata_q, rdata_d;

  logic             req, is_status, is_read, pop, w1c;
  logic [7:0]       fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [31:0]      status_word;
  logic             unused_bits;

  assign unused_bits = ^{mem_addr[31:3], mem_addr[1:0], mem_wdata[31:4], mem_wdata[1:0]};

  assign tick  = (div_q == DIV_W'(DIV - 1));
  assign div_d = tick ? '0 : div_q + 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      div_q   <= '0;
    end else begin
      sync1_q <= serialIn;
      rx_s_q  <= sync1_q;
      div_q   <= div_d;
    end
  end

  // Frame FSM: state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      samp_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign sample = tick && (samp_q == SAMPLE_POINT);

  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (tick && (state_q == ST_START || state_q == ST_DATA || state_q == ST_STOP))
      samp_d = samp_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d = ST_START;
          samp_d  = '0;
        end
      end
      ST_START: begin
        if (sample) begin
          if (rx_s_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            bit_d   = '0;
          end
        end
      end
      ST_DATA: begin
        if (sample) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample) state_d = rx_s_q ? ST_IDLE : ST_BREAK;
      end
      ST_BREAK: begin
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    push     = 1'b0;
    ferr_set = 1'b0;
    if (state_q == ST_STOP && sample) begin
      push     = rx_s_q;
      ferr_set = ~rx_s_q;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (shift_q),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Bus decode, sticky flags and registered response
  assign req       = mem_valid & enable & ~ready_q;
  assign is_status = (mem_addr[2] == REG_STATUS);
  assign is_read   = (mem_wstrb == 4'b0000);
  assign pop       = req & is_read & ~is_status & ~mem_instr & ~fifo_empty;
  assign w1c       = req & is_status & mem_wstrb[0];

  always_comb begin
    status_word = '0;
    status_word[ST_AVAIL_BIT] = ~fifo_empty;
    status_word[ST_FULL_BIT]  = fifo_full;
    status_word[ST_OVR_BIT]   = ovr_q;
    status_word[ST_FERR_BIT]  = ferr_q;
    status_word[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(fifo_count);
  end

  always_comb begin
    ovr_d   = (push & fifo_full & ~pop) | (ovr_q & ~(w1c & mem_wdata[ST_OVR_BIT]));
    ferr_d  = ferr_set | (ferr_q & ~(w1c & mem_wdata[ST_FERR_BIT]));
    ready_d = req;
    rdata_d = '0;
    if (req && is_read) begin
      if (is_status)        rdata_d = status_word;
      else if (!fifo_empty) rdata_d = {23'b0, 1'b1, fifo_rdata};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      irq_q   <= ~fifo_empty;
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign rx_irq    = irq_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 1.6 MHz / 10 kBd (DIV=10, 160 clocks per bit).
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_wdata = '0;
  logic        serialIn = 1'b1;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        rx_irq;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  uart_rx #(
    .CLK_HZ     (1600000),
    .BAUD       (10000),
    .FIFO_DEPTH (8)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (enable),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .serialIn  (serialIn),
    .rx_irq    (rx_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Line is left at the stop level so a low stop can be stretched into a break.
  task automatic send_byte(input logic [7:0] b, input logic stop_lvl);
    serialIn = 1'b0;
    repeat (160) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serialIn = b[i];
      repeat (160) @(negedge clk);
    end
    serialIn = stop_lvl;
    repeat (160) @(negedge clk);
  endtask

  task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] wstrb,
                          input logic [31:0] wdata, input logic instr,
                          output logic [31:0] rdata);
    logic got;
    got = 1'b0;
    rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_valid = 1'b1; enable = 1'b1; mem_addr = addr;
    mem_wstrb = wstrb; mem_wdata = wdata; mem_instr = instr;
    for (int i = 0; i < 8; i++) begin
      if (!got) begin
        @(posedge clk); #1;
        if (mem_ready) begin
          rdata = mem_rdata;
          got = 1'b1;
        end
      end
    end
    @(negedge clk);
    mem_valid = 1'b0; enable = 1'b0; mem_wstrb = '0; mem_instr = 1'b0;
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL bus_timeout addr=%h: mem_ready never seen, required within 8 cycles", addr);
    end
  endtask

  task automatic wait_aligned();
    while (cyc % 160 != 0) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (mem_ready !== 1'b0 || mem_rdata !== 32'h0 || rx_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b rdata=%h irq=%b, required 0/0/0", mem_ready, mem_rdata, rx_irq);
    end
    @(negedge clk); resetn = 1'b1;
    repeat (5) @(negedge clk);
    bus_xfer(32'h4, 4'h0, 32'h0, 1'b0, d);
    n_chk++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h, required 00000000", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    send_byte(8'h55, 1'b1);
    send_byte(8'hA3, 1'b1);
    repeat (20) @(negedge clk);
    n_chk++;
    if (rx_irq !== 1'b1) begin n_fail++; $display("FAIL b2b_irq: got %b, required 1", rx_irq); end
    bus_xfer(32'h4, 4'h0, 32'h0, 1'b0, d);
    n_chk++;
    if (d !== 32'h201) begin n_fail++; $display("FAIL b2b_status: got %h, required 00000201", d); end
    bus_xfer(32'h0, 4'h0, 32'h0, 1'b1, d);
    n_chk++;
    if (d !== 32'h155) begin n_fail++; $display("FAIL b2b_instr_read: got %h, required 00000155", d); end
    bus_xfer(32'h0, 4'hF, 32'hFF, 1'b0, d);
    bus_xfer(32'h4, 4'h0, 32'h0, 1'b0, d);
    n_chk++;
    if (d !== 32'h201) begin n_fail++; $display("FAIL b2b_status_after_nopop: got %h, required 00000201", d); end
    bus_xfer(32'h0, 4'h0, 32'h0, 1'b0, d);
    n_chk++;
    if (d !== 32'h155) begin n_fail++; $display("FAIL b2b_byte0: got %h, required 00000155", d); end
    bus_xfer(32'h0, 4'h0, 32'h0, 1'b0, d);
    n_chk++;
    if (d !== 32'h1A3) begin n_fail++; $display("FAIL b2b_byte1: got %h, required 000001a3", d); end
    bus_xfer(32'h4, 4'h0, 32'h0, 1'b0, d);
    n_chk++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL b2b_status_empty: got %h, required 00000000", d); end
    repeat (3) @(negedge clk);
    n_chk++;
    if (rx_irq !== 1'b0) begin n_fail++; $display("FAIL b2b_irq_clear: got %b, required 0", rx_irq); end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    @(negedge clk); serialIn = 1'b0;
    repeat (60) @(negedge clk);
    serialIn = 1'b1;
    repeat (300) @(negedge clk);
    bus_xfer(32'h4, 4'h0, 32'h0, 1'b0, d);
    n_chk++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_status: got %h, required 00000000", d); end
    send_byte(8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    bus_xfer(32'h0, 4'h0, 32'h0, 1'b0, d);
    n_chk++;
    if (d !== 32'h13C) begin n_fail++; $display("FAIL glitch_next_frame: got %h, required 0000013c", d); end
  endtask

  task automatic test_frame_err();
    logic [31:0] d;
    send_byte(8'h41, 1'b0);
    repeat (320) @(negedge clk);
    serialIn = 1'b1;
    repeat (200) @(negedge clk);
    bus_xfer(32'h4, 4'h0, 32'h0, 1'b0, d);
    n_chk++;
    if (d !== 32'h8) begin n_fail++; $display("FAIL ferr_status: got %h, required 00000008", d); end
    bus_xfer(32'h0, 4'h0, 32'h0, 1'b0, d);
    n_chk++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL ferr_rxdata_empty: got %h, required 00000000", d); end
    bus_xfer(32'h4, 4'h1, 32'h8, 1'b0, d);
    bus_xfer(32'h4, 4'h0, 32'h0, 1'b0, d);
    n_chk++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL ferr_cleared: got %h, required 00000000", d); end
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    for (int i = 0; i < 9; i++) send_byte(8'(i), 1'b1);
    repeat (20) @(negedge clk);
    bus_xfer(32'h4, 4'h0, 32'h0, 1'b0, d);
    n_chk++;
    if (d !== 32'h807) begin n_fail++; $display("FAIL ovr_status_full: got %h, required 00000807", d); end
    for (int i = 0; i < 8; i++) begin
      bus_xfer(32'h0, 4'h0, 32'h0, 1'b0, d);
      n_chk++;
      if (d !== (32'h100 | i)) begin
        n_fail++;
        $display("FAIL ovr_drain[%0d]: got %h, required %h", i, d, 32'h100 | i);
      end
    end
    bus_xfer(32'h4, 4'h0, 32'h0, 1'b0, d);
    n_chk++;
    if (d !== 32'h4) begin n_fail++; $display("FAIL ovr_status_drained: got %h, required 00000004", d); end
    bus_xfer(32'h4, 4'h1, 32'h4, 1'b0, d);
    bus_xfer(32'h4, 4'h0, 32'h0, 1'b0, d);
    n_chk++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL ovr_cleared: got %h, required 00000000", d); end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] d;
    int t0, nirq, off;
    logic found;
    found = 1'b0;
    nirq = 0;
    // Measure push timing relative to an aligned frame start using rx_irq on an empty FIFO
    wait_aligned();
    t0 = cyc;
    fork
      send_byte(8'h5A, 1'b1);
      begin
        for (int i = 0; i < 3000; i++) begin
          if (!found) begin
            @(posedge clk); #1;
            if (rx_irq) begin found = 1'b1; nirq = cyc; end
          end
        end
      end
    join
    n_chk++;
    if (!found) begin n_fail++; $display("FAIL ppf_calib: rx_irq never rose, required within 3000 cycles"); end
    off = nirq - 1 - t0;
    bus_xfer(32'h0, 4'h0, 32'h0, 1'b0, d);
    n_chk++;
    if (d !== 32'h15A) begin n_fail++; $display("FAIL ppf_calib_byte: got %h, required 0000015a", d); end
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b1);
    repeat (20) @(negedge clk);
    bus_xfer(32'h4, 4'h0, 32'h0, 1'b0, d);
    n_chk++;
    if (d !== 32'h803) begin n_fail++; $display("FAIL ppf_status_full: got %h, required 00000803", d); end
    wait_aligned();
    t0 = cyc;
    fork
      send_byte(8'h18, 1'b1);
      begin
        while (cyc < t0 + off - 2) @(negedge clk);
        bus_xfer(32'h0, 4'h0, 32'h0, 1'b0, d);
      end
    join
    n_chk++;
    if (d !== 32'h110) begin n_fail++; $display("FAIL ppf_coincident_pop: got %h, required 00000110", d); end
    repeat (20) @(negedge clk);
    bus_xfer(32'h4, 4'h0, 32'h0, 1'b0, d);
    n_chk++;
    if (d !== 32'h803) begin n_fail++; $display("FAIL ppf_status_after: got %h, required 00000803", d); end
    for (int i = 1; i < 9; i++) begin
      bus_xfer(32'h0, 4'h0, 32'h0, 1'b0, d);
      n_chk++;
      if (d !== (32'h110 + i)) begin
        n_fail++;
        $display("FAIL ppf_drain[%0d]: got %h, required %h", i, d, 32'h110 + i);
      end
    end
    bus_xfer(32'h4, 4'h0, 32'h0, 1'b0, d);
    n_chk++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL ppf_status_empty: got %h, required 00000000", d); end
  endtask

  task automatic test_empty_hold();
    logic [31:0] d;
    int pulses;
    pulses = 0;
    @(negedge clk);
    mem_valid = 1'b1; enable = 1'b1; mem_addr = 32'h0; mem_wstrb = 4'h0; mem_instr = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (mem_ready !== 1'b1 || mem_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL hold_first: ready=%b rdata=%h, required 1/00000000", mem_ready, mem_rdata);
    end
    @(posedge clk); #1;
    n_chk++;
    if (mem_ready !== 1'b0 || mem_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL hold_second: ready=%b rdata=%h, required 0/00000000", mem_ready, mem_rdata);
    end
    @(negedge clk);
    mem_valid = 1'b0; enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (mem_ready) pulses++;
    end
    n_chk++;
    if (pulses != 0) begin n_fail++; $display("FAIL hold_trailing: %0d extra ready cycles, required 0", pulses); end
    bus_xfer(32'h4, 4'h0, 32'h0, 1'b0, d);
    n_chk++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL hold_status: got %h, required 00000000", d); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    send_byte(8'h31, 1'b1);
    send_byte(8'h32, 1'b1);
    send_byte(8'h33, 1'b1);
    repeat (20) @(negedge clk);
    bus_xfer(32'h4, 4'h0, 32'h0, 1'b0, d);
    n_chk++;
    if (d !== 32'h301) begin n_fail++; $display("FAIL rst_status_queued: got %h, required 00000301", d); end
    serialIn = 1'b0;
    repeat (560) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    n_chk++;
    if (mem_ready !== 1'b0 || mem_rdata !== 32'h0 || rx_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: ready=%b rdata=%h irq=%b, required 0/0/0", mem_ready, mem_rdata, rx_irq);
    end
    serialIn = 1'b1;
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    bus_xfer(32'h4, 4'h0, 32'h0, 1'b0, d);
    n_chk++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL rst_status_after: got %h, required 00000000", d); end
    send_byte(8'h7E, 1'b1);
    repeat (20) @(negedge clk);
    bus_xfer(32'h0, 4'h0, 32'h0, 1'b0, d);
    n_chk++;
    if (d !== 32'h17E) begin n_fail++; $display("FAIL rst_next_frame: got %h, required 0000017e", d); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_push_pop_full();
    test_empty_hold();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
